// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the ROB commit unit: CDB field layout, writeback
// type encodings, the ROB entry record and small entry helpers.
package rob_commit_unit_pkg;

  // Fixed CDB geometry: two slots of {valid, tag[3:0], data[15:0]}
  localparam int CDB_W          = 42;
  localparam int PKG_TAG_W      = 4;
  localparam int PKG_DATA_W     = 16;
  localparam int PKG_RADDR_W    = 5;

  localparam int CDB_V_HI       = 41;
  localparam int CDB_TAG_HI_MSB = 40;
  localparam int CDB_TAG_HI_LSB = 37;
  localparam int CDB_DATA_HI_MSB = 36;
  localparam int CDB_DATA_HI_LSB = 21;
  localparam int CDB_V_LO       = 20;
  localparam int CDB_TAG_LO_MSB = 19;
  localparam int CDB_TAG_LO_LSB = 16;
  localparam int CDB_DATA_LO_MSB = 15;
  localparam int CDB_DATA_LO_LSB = 0;

  typedef enum logic [1:0] {
    WB_REG = 2'b00,
    WB_MEM = 2'b01
  } wb_type_e;

  typedef struct packed {
    logic                   busy;
    logic                   done;
    wb_type_e               wb_type;
    logic [PKG_RADDR_W-1:0] dest;
    logic [PKG_DATA_W-1:0]  data;
  } rob_entry_t;

  localparam rob_entry_t ROB_ENTRY_CLEAR = '{
    busy:    1'b0,
    done:    1'b0,
    wb_type: WB_REG,
    dest:    5'd0,
    data:    16'd0
  };

  // A register-type entry writes the ARF unless its destination is r0
  function automatic logic writes_reg(input rob_entry_t e);
    return (e.wb_type == WB_REG) && (e.dest != {PKG_RADDR_W{1'b0}});
  endfunction

  function automatic logic is_mem(input rob_entry_t e);
    return (e.wb_type == WB_MEM);
  endfunction

endpackage

// File: rtl/rob_commit_unit_cdb_match.sv
// Per-entry CDB snooper: compares both CDB slots against one entry tag and
// returns the hit plus the matching result; the lo slot wins a double match.
module rob_cdb_match
  import rob_commit_unit_pkg::*;
(
  input  logic [CDB_W-1:0]      cdb_data,
  input  logic [PKG_TAG_W-1:0]  entry_tag,
  output logic                  hit,
  output logic [PKG_DATA_W-1:0] data
);

  logic lo_hit_s;
  logic hi_hit_s;

  assign lo_hit_s = cdb_data[CDB_V_LO] &&
                    (cdb_data[CDB_TAG_LO_MSB:CDB_TAG_LO_LSB] == entry_tag);
  assign hi_hit_s = cdb_data[CDB_V_HI] &&
                    (cdb_data[CDB_TAG_HI_MSB:CDB_TAG_HI_LSB] == entry_tag);

  // Select the matching slot, lo slot checked first
  always_comb begin
    hit  = 1'b0;
    data = {PKG_DATA_W{1'b0}};
    if (lo_hit_s) begin
      hit  = 1'b1;
      data = cdb_data[CDB_DATA_LO_MSB:CDB_DATA_LO_LSB];
    end else if (hi_hit_s) begin
      hit  = 1'b1;
      data = cdb_data[CDB_DATA_HI_MSB:CDB_DATA_HI_LSB];
    end else begin
      hit  = 1'b0;
      data = {PKG_DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer commit unit: allocates up to two entries per cycle, snoops
// the dual-slot CDB to mark entries done, and retires up to two done entries
// per cycle in program order onto the ARF write ports / store buffer.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH   = 8,
  parameter int TAG_WIDTH   = PKG_TAG_W,
  parameter int DATA_WIDTH  = PKG_DATA_W,
  parameter int RADDR_WIDTH = PKG_RADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             alloc_valid,
  input  logic [1:0]             alloc_is_store,
  input  logic [RADDR_WIDTH-1:0] alloc_dest0,
  input  logic [RADDR_WIDTH-1:0] alloc_dest1,
  output logic                   alloc_ready,
  output logic [TAG_WIDTH-1:0]   alloc_tag0,
  output logic [TAG_WIDTH-1:0]   alloc_tag1,
  input  logic [CDB_W-1:0]       cdb_data,
  output logic [1:0]             reg_we,
  output logic [RADDR_WIDTH-1:0] reg_waddr0,
  output logic [RADDR_WIDTH-1:0] reg_waddr1,
  output logic [DATA_WIDTH-1:0]  reg_wdata0,
  output logic [DATA_WIDTH-1:0]  reg_wdata1,
  output logic [1:0]             store_commit,
  output logic [TAG_WIDTH-1:0]   commit_tag0,
  output logic [TAG_WIDTH-1:0]   commit_tag1,
  output logic [TAG_WIDTH:0]     rob_count,
  output logic                   rob_empty
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = TAG_WIDTH + 1;

  rob_entry_t            entries_r [ROB_DEPTH];
  rob_entry_t            entries_s [ROB_DEPTH];
  logic [IDX_W-1:0]      head_r, head_s;
  logic [IDX_W-1:0]      tail_r, tail_s;
  logic [CNT_W-1:0]      count_r, count_s;

  logic                  cdb_hit_s [ROB_DEPTH];
  logic [PKG_DATA_W-1:0] cdb_val_s [ROB_DEPTH];

  logic [IDX_W-1:0]      head1_s;
  logic [IDX_W-1:0]      tail1_s;
  rob_entry_t            head_entry_s;
  rob_entry_t            next_entry_s;
  logic                  ret0_s, ret1_s;
  logic                  alloc_go_s, alloc_two_s;

  genvar g;
  generate
    for (g = 0; g < ROB_DEPTH; g++) begin : g_match
      rob_cdb_match u_match (
        .cdb_data  (cdb_data),
        .entry_tag (PKG_TAG_W'(g)),
        .hit       (cdb_hit_s[g]),
        .data      (cdb_val_s[g])
      );
    end
  endgenerate

  assign head1_s      = head_r + IDX_W'(1'b1);
  assign tail1_s      = tail_r + IDX_W'(1'b1);
  assign head_entry_s = entries_r[head_r];
  assign next_entry_s = entries_r[head1_s];

  // Dispatch handshake: room for a full pair is required before any grant
  assign alloc_ready = ((CNT_W'(ROB_DEPTH) - count_r) >= CNT_W'(2'd2));
  assign alloc_tag0  = TAG_WIDTH'(tail_r);
  assign alloc_tag1  = TAG_WIDTH'(tail1_s);
  assign rob_count   = count_r;
  assign rob_empty   = (count_r == {CNT_W{1'b0}});

  // Grants and in-order retire decisions, all taken from registered state
  assign alloc_go_s  = alloc_ready && alloc_valid[0] && !flush;
  assign alloc_two_s = alloc_go_s && alloc_valid[1];
  assign ret0_s      = !flush && head_entry_s.busy && head_entry_s.done;
  assign ret1_s      = ret0_s && next_entry_s.busy && next_entry_s.done;

  // Next entry array and pointers: flush, then retire over CDB, then alloc
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      entries_s[i] = entries_r[i];
    end
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_s[i] = ROB_ENTRY_CLEAR;
      end
      head_s  = {IDX_W{1'b0}};
      tail_s  = {IDX_W{1'b0}};
      count_s = {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (entries_r[i].busy && cdb_hit_s[i]) begin
          entries_s[i].done = 1'b1;
          entries_s[i].data = cdb_val_s[i];
        end else begin
          entries_s[i] = entries_s[i];
        end
      end
      if (ret0_s) begin
        entries_s[head_r] = ROB_ENTRY_CLEAR;
      end else begin
        entries_s[head_r] = entries_s[head_r];
      end
      if (ret1_s) begin
        entries_s[head1_s] = ROB_ENTRY_CLEAR;
      end else begin
        entries_s[head1_s] = entries_s[head1_s];
      end
      // Allocated slots are free, so they never collide with retiring ones
      if (alloc_go_s) begin
        entries_s[tail_r] = '{busy: 1'b1, done: 1'b0,
                              wb_type: (alloc_is_store[0] ? WB_MEM : WB_REG),
                              dest: alloc_dest0, data: {PKG_DATA_W{1'b0}}};
      end else begin
        entries_s[tail_r] = entries_s[tail_r];
      end
      if (alloc_two_s) begin
        entries_s[tail1_s] = '{busy: 1'b1, done: 1'b0,
                               wb_type: (alloc_is_store[1] ? WB_MEM : WB_REG),
                               dest: alloc_dest1, data: {PKG_DATA_W{1'b0}}};
      end else begin
        entries_s[tail1_s] = entries_s[tail1_s];
      end
      head_s  = head_r + IDX_W'(ret0_s) + IDX_W'(ret1_s);
      tail_s  = tail_r + IDX_W'(alloc_go_s) + IDX_W'(alloc_two_s);
      count_s = count_r + CNT_W'(alloc_go_s) + CNT_W'(alloc_two_s)
                        - CNT_W'(ret0_s) - CNT_W'(ret1_s);
    end
  end

  // Entry array and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i] <= ROB_ENTRY_CLEAR;
      end
      head_r  <= {IDX_W{1'b0}};
      tail_r  <= {IDX_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i] <= entries_s[i];
      end
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
    end
  end

  // Registered commit outputs: one-cycle pulses, zero whenever nothing retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we       <= 2'b00;
      store_commit <= 2'b00;
      reg_waddr0   <= {RADDR_WIDTH{1'b0}};
      reg_waddr1   <= {RADDR_WIDTH{1'b0}};
      reg_wdata0   <= {DATA_WIDTH{1'b0}};
      reg_wdata1   <= {DATA_WIDTH{1'b0}};
      commit_tag0  <= {TAG_WIDTH{1'b0}};
      commit_tag1  <= {TAG_WIDTH{1'b0}};
    end else if (flush) begin
      reg_we       <= 2'b00;
      store_commit <= 2'b00;
      reg_waddr0   <= {RADDR_WIDTH{1'b0}};
      reg_waddr1   <= {RADDR_WIDTH{1'b0}};
      reg_wdata0   <= {DATA_WIDTH{1'b0}};
      reg_wdata1   <= {DATA_WIDTH{1'b0}};
      commit_tag0  <= {TAG_WIDTH{1'b0}};
      commit_tag1  <= {TAG_WIDTH{1'b0}};
    end else begin
      reg_we[0]       <= ret0_s && writes_reg(head_entry_s);
      reg_we[1]       <= ret1_s && writes_reg(next_entry_s);
      store_commit[0] <= ret0_s && is_mem(head_entry_s);
      store_commit[1] <= ret1_s && is_mem(next_entry_s);
      reg_waddr0 <= (ret0_s && writes_reg(head_entry_s)) ? head_entry_s.dest
                                                         : {RADDR_WIDTH{1'b0}};
      reg_waddr1 <= (ret1_s && writes_reg(next_entry_s)) ? next_entry_s.dest
                                                         : {RADDR_WIDTH{1'b0}};
      reg_wdata0 <= (ret0_s && writes_reg(head_entry_s)) ? head_entry_s.data
                                                         : {DATA_WIDTH{1'b0}};
      reg_wdata1 <= (ret1_s && writes_reg(next_entry_s)) ? next_entry_s.data
                                                         : {DATA_WIDTH{1'b0}};
      commit_tag0 <= ret0_s ? TAG_WIDTH'(head_r)  : {TAG_WIDTH{1'b0}};
      commit_tag1 <= ret1_s ? TAG_WIDTH'(head1_s) : {TAG_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: stimulus pushes the expected commit
// pulse (with its cycle) into a queue, a negedge monitor pops and compares.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  alloc_valid = 2'b00;
  logic [1:0]  alloc_is_store = 2'b00;
  logic [4:0]  alloc_dest0 = 5'd0;
  logic [4:0]  alloc_dest1 = 5'd0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag0, alloc_tag1;
  logic [41:0] cdb_data = 42'd0;
  logic [1:0]  reg_we;
  logic [4:0]  reg_waddr0, reg_waddr1;
  logic [15:0] reg_wdata0, reg_wdata1;
  logic [1:0]  store_commit;
  logic [3:0]  commit_tag0, commit_tag1;
  logic [4:0]  rob_count;
  logic        rob_empty;

  rob_commit_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_dest0(alloc_dest0), .alloc_dest1(alloc_dest1),
    .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .cdb_data(cdb_data),
    .reg_we(reg_we), .reg_waddr0(reg_waddr0), .reg_waddr1(reg_waddr1),
    .reg_wdata0(reg_wdata0), .reg_wdata1(reg_wdata1),
    .store_commit(store_commit), .commit_tag0(commit_tag0), .commit_tag1(commit_tag1),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ret;
    logic [1:0] we;
    logic [1:0] st;
    logic [3:0] tag0, tag1;
    logic [4:0] wa0, wa1;
    logic [15:0] wd0, wd1;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mdl_count;
  int   mdl_tail;

  // Cycle counter, one step per rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit pulse must match the oldest expected record
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (reg_we != 2'b00 || store_commit != 2'b00)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", {28'd0, reg_we, store_commit}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_cycle", cyc, e.cyc);
        chk("reg_we", {30'd0, reg_we}, {30'd0, e.we});
        chk("store_commit", {30'd0, store_commit}, {30'd0, e.st});
        if (e.ret[0]) chk("commit_tag0", {28'd0, commit_tag0}, {28'd0, e.tag0});
        if (e.ret[1]) chk("commit_tag1", {28'd0, commit_tag1}, {28'd0, e.tag1});
        if (e.we[0]) begin
          chk("reg_waddr0", {27'd0, reg_waddr0}, {27'd0, e.wa0});
          chk("reg_wdata0", {16'd0, reg_wdata0}, {16'd0, e.wd0});
        end
        if (e.we[1]) begin
          chk("reg_waddr1", {27'd0, reg_waddr1}, {27'd0, e.wa1});
          chk("reg_wdata1", {16'd0, reg_wdata1}, {16'd0, e.wd1});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] v, input logic [1:0] st,
                       input logic [4:0] d0, input logic [4:0] d1);
    alloc_valid = v; alloc_is_store = st; alloc_dest0 = d0; alloc_dest1 = d1;
    tick();
    alloc_valid = 2'b00; alloc_is_store = 2'b00;
  endtask

  task automatic cdb(input logic vlo, input logic [3:0] tlo, input logic [15:0] dlo,
                     input logic vhi, input logic [3:0] thi, input logic [15:0] dhi);
    cdb_data = {vhi, thi, dhi, vlo, tlo, dlo};
  endtask

  // Called in the cycle the CDB is driven; the pulse appears two edges later
  task automatic push_exp(input logic [1:0] ret, input logic [1:0] we, input logic [1:0] st,
                          input logic [3:0] t0, input logic [3:0] t1,
                          input logic [4:0] wa0, input logic [4:0] wa1,
                          input logic [15:0] wd0, input logic [15:0] wd1);
    exp_t e;
    e.cyc = cyc + 2; e.ret = ret; e.we = we; e.st = st;
    e.tag0 = t0; e.tag1 = t1; e.wa0 = wa0; e.wa1 = wa1; e.wd0 = wd0; e.wd1 = wd1;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_count", {27'd0, rob_count}, 32'd0);
    chk("rst_reg_we", {30'd0, reg_we}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_empty", {31'd0, rob_empty}, 32'd1);
    chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
    chk("rst_tag0", {28'd0, alloc_tag0}, 32'd0);
    chk("rst_tag1", {28'd0, alloc_tag1}, 32'd1);

    // Dual alloc, both CDB slots complete together -> dual retire
    alloc(2'b11, 2'b00, 5'd3, 5'd4);
    chk("t1_count", {27'd0, rob_count}, 32'd2);
    cdb(1'b1, 4'd0, 16'h0011, 1'b1, 4'd1, 16'h0022);
    push_exp(2'b11, 2'b11, 2'b00, 4'd0, 4'd1, 5'd3, 5'd4, 16'h0011, 16'h0022);
    tick(); cdb_data = 42'd0; tick(); tick();
    chk("t1_drained", {27'd0, rob_count}, 32'd0);

    // Out-of-order completion: younger first holds, older releases both
    chk("t2_tag0", {28'd0, alloc_tag0}, 32'd2);
    alloc(2'b11, 2'b00, 5'd5, 5'd6);
    cdb(1'b1, 4'd3, 16'h0033, 1'b0, 4'd0, 16'h0000);
    tick(); cdb_data = 42'd0; tick(); tick();
    chk("t2_held", {27'd0, rob_count}, 32'd2);
    cdb(1'b1, 4'd2, 16'h0044, 1'b0, 4'd0, 16'h0000);
    push_exp(2'b11, 2'b11, 2'b00, 4'd2, 4'd3, 5'd5, 5'd6, 16'h0044, 16'h0033);
    tick(); cdb_data = 42'd0; tick(); tick();
    chk("t2_drained", {27'd0, rob_count}, 32'd0);

    // Fill all 8 entries (tags 4..7,0..3), overflow alloc dropped
    for (int j = 0; j < 4; j++) begin
      chk("fill_tag", {28'd0, alloc_tag0}, 32'((4 + 2*j) % 8));
      alloc(2'b11, 2'b00, 5'(8 + 2*j), 5'(9 + 2*j));
    end
    chk("fill_count", {27'd0, rob_count}, 32'd8);
    chk("fill_ready", {31'd0, alloc_ready}, 32'd0);
    alloc(2'b01, 2'b00, 5'd20, 5'd0);
    chk("fill_overflow", {27'd0, rob_count}, 32'd8);
    for (int j = 0; j < 4; j++) begin
      cdb(1'b1, 4'((4 + 2*j) % 8), 16'(16'hA000 + 2*j),
          1'b1, 4'((5 + 2*j) % 8), 16'(16'hA001 + 2*j));
      push_exp(2'b11, 2'b11, 2'b00, 4'((4 + 2*j) % 8), 4'((5 + 2*j) % 8),
               5'(8 + 2*j), 5'(9 + 2*j), 16'(16'hA000 + 2*j), 16'(16'hA001 + 2*j));
      tick();
    end
    cdb_data = 42'd0; tick(); tick(); tick();
    chk("fill_drained", {27'd0, rob_count}, 32'd0);

    // Seven occupied entries leave only one free: not ready
    alloc(2'b11, 2'b00, 5'd1, 5'd2);
    alloc(2'b11, 2'b00, 5'd1, 5'd2);
    alloc(2'b11, 2'b00, 5'd1, 5'd2);
    chk("six_ready", {31'd0, alloc_ready}, 32'd1);
    alloc(2'b01, 2'b00, 5'd1, 5'd0);
    chk("seven_count", {27'd0, rob_count}, 32'd7);
    chk("seven_ready", {31'd0, alloc_ready}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush7_count", {27'd0, rob_count}, 32'd0);

    // Flush with 5 busy entries, done head and a same-cycle CDB hit
    alloc(2'b11, 2'b00, 5'd1, 5'd2);
    alloc(2'b11, 2'b00, 5'd3, 5'd4);
    alloc(2'b01, 2'b00, 5'd5, 5'd0);
    chk("pre_flush_count", {27'd0, rob_count}, 32'd5);
    cdb(1'b1, 4'd0, 16'h0055, 1'b0, 4'd0, 16'h0000);
    tick();
    flush = 1'b1;
    cdb(1'b1, 4'd1, 16'h0066, 1'b0, 4'd0, 16'h0000);
    tick();
    flush = 1'b0; cdb_data = 42'd0;
    chk("flush_count", {27'd0, rob_count}, 32'd0);
    tick(); tick();
    chk("flush_no_we", {30'd0, reg_we}, 32'd0);
    chk("flush_tag0", {28'd0, alloc_tag0}, 32'd0);

    // Store at tag 2, dest r0 at tag 3
    alloc(2'b11, 2'b00, 5'd7, 5'd9);
    alloc(2'b11, 2'b01, 5'd6, 5'd0);
    chk("st_count4", {27'd0, rob_count}, 32'd4);
    cdb(1'b1, 4'd0, 16'h0101, 1'b1, 4'd1, 16'h0202);
    push_exp(2'b11, 2'b11, 2'b00, 4'd0, 4'd1, 5'd7, 5'd9, 16'h0101, 16'h0202);
    tick(); cdb_data = 42'd0; tick(); tick();
    chk("st_count2", {27'd0, rob_count}, 32'd2);
    cdb(1'b1, 4'd2, 16'h0303, 1'b1, 4'd3, 16'h0404);
    push_exp(2'b11, 2'b00, 2'b01, 4'd2, 4'd3, 5'd0, 5'd0, 16'h0000, 16'h0000);
    tick(); cdb_data = 42'd0; tick(); tick();
    chk("st_count0", {27'd0, rob_count}, 32'd0);

    // Wrap: 20 single rounds, tags continue from 4 and cycle modulo 8
    mdl_count = 0;
    mdl_tail  = 4;
    for (int r = 0; r < 20; r++) begin
      chk("wrap_tag", {28'd0, alloc_tag0}, 32'(mdl_tail));
      alloc(2'b01, 2'b00, 5'((r % 31) + 1), 5'd0);
      mdl_count++;
      chk("wrap_count_alloc", {27'd0, rob_count}, 32'(mdl_count));
      if (r == 3) cdb(1'b1, 4'(mdl_tail), 16'(16'h1000 + r), 1'b1, 4'(mdl_tail), 16'hBEEF);
      else        cdb(1'b1, 4'(mdl_tail), 16'(16'h1000 + r), 1'b0, 4'd0, 16'h0000);
      push_exp(2'b01, 2'b01, 2'b00, 4'(mdl_tail), 4'd0, 5'((r % 31) + 1), 5'd0,
               16'(16'h1000 + r), 16'h0000);
      tick(); cdb_data = 42'd0; tick(); tick();
      mdl_count--;
      mdl_tail = (mdl_tail + 1) % 8;
      chk("wrap_count_retire", {27'd0, rob_count}, 32'(mdl_count));
    end

    // Reset while commit pulses are on the outputs
    alloc(2'b11, 2'b00, 5'd10, 5'd11);
    cdb(1'b1, 4'd0, 16'h7777, 1'b1, 4'd1, 16'h8888);
    tick(); cdb_data = 42'd0; tick();
    chk("pre_rst_we", {30'd0, reg_we}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", {30'd0, reg_we}, 32'd0);
    chk("rst_mid_tag1", {28'd0, commit_tag1}, 32'd0);
    chk("rst_mid_count", {27'd0, rob_count}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_tag0", {28'd0, alloc_tag0}, 32'd0);
    chk("post_rst_empty", {31'd0, rob_empty}, 32'd1);

    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
